ss_bus_responder: RTL and testbench
===================================

# ss_bus_responder

Native-memory-bus responder for the subsystem: accepts `mem_valid` requests from the core or testbench initiator, serves a word-addressed SRAM and a two-register UART, and drives the serial `uart_tx` line while sampling `uart_rx`. It is the target end of the `mem_*` handshake and the far end of both UART wires, and acts as the reference peer for the initiator-side bench.

## Interface
- `MEM_WORDS`, 1024: number of 32-bit SRAM words; power of two, at least 16.
- `CLK_DIV`, 16: clock cycles per UART bit; at least 4.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `mem_valid` input 1: request valid, held until `mem_ready`.
- `mem_addr` input 32: byte address, bits [1:0] ignored.
- `mem_wdata` input 32: write data.
- `mem_wstrb` input 4: byte-lane write enables; 0 means read.
- `mem_rdata` output 32: read data, valid only while `mem_ready`=1.
- `mem_ready` output 1: one-cycle completion pulse.
- `uart_tx` output 1: serial transmit, 8N1, LSB first, idle high.
- `uart_rx` input 1: serial receive, asynchronous to `clk`.

## Operation
- Address map:
  - SRAM at 0x0000_0000 to 4*MEM_WORDS-1.
  - UART DATA at 0x1000_0000.
  - UART STATUS at 0x1000_0004.
  - Unmapped addresses: reads return 0, writes are dropped, and `mem_ready` is still given.
- SRAM:
  - Each `mem_wstrb` bit writes its byte lane.
  - Reads return the full word.
  - Contents are not reset.
- DATA write:
  - Effective only if `mem_wstrb[0]`=1; loads `mem_wdata[7:0]` into the transmitter.
  - If other lanes are set without lane 0, the write is ignored but still acknowledged.
- DATA read:
  - Returns {24'b0, rx_byte}.
  - Clears rx_valid.
- STATUS read:
  - Returns {29'b0, rx_overrun, rx_valid, tx_busy}.
  - Clears rx_overrun.
  - Writes to STATUS are ignored.
- FSM states:
  - IDLE: sample `mem_valid`. If high and the access is a DATA write with tx_busy=1, go to WAIT_TX. Otherwise perform the access and go to RESP.
  - WAIT_TX: hold until tx_busy=0, then load the transmitter and go to RESP.
  - RESP: `mem_ready`=1 with `mem_rdata` valid, then go to TURN.
  - TURN: `mem_valid` is ignored (initiator deassert cycle), then go to IDLE.
- TX:
  - Frame is start(0), d0..d7, stop(1), each bit CLK_DIV cycles.
  - tx_busy is set on load and cleared at the end of the stop bit.
- RX:
  - 2-flop synchroniser on `uart_rx`.
  - A falling edge in idle starts a frame; every bit is sampled at CLK_DIV/2 into its period.
  - If the start bit is not 0 at its midpoint, the frame is aborted and the receiver returns to idle.
  - If the stop bit is 0, the byte is discarded.
  - A completed byte with rx_valid=0 is stored and sets rx_valid.
  - A completed byte with rx_valid=1 is discarded and sets rx_overrun.
  - If a byte completes in the same cycle as a DATA read, the read returns the old byte, the new byte is stored, and rx_valid stays 1.

## Timing
- Reset values:
  - `mem_ready`=0, `mem_rdata`=0, `uart_tx`=1.
  - FSM in IDLE.
  - tx_busy=0, rx_valid=0, rx_overrun=0.
- Reset mid-operation:
  - An in-flight access is abandoned and no `mem_ready` is issued.
  - A partial TX frame is cut and `uart_tx` returns high immediately.
  - A partial RX frame is dropped.
- Read/write latency: `mem_valid` sampled high in IDLE at edge N gives `mem_ready`=1 in the cycle after edge N+1, for exactly one cycle.
- Minimum spacing: 3 cycles per access (IDLE, RESP, TURN).
- Stalled DATA write: `mem_ready` follows 1 cycle after tx_busy falls.
- TX start: the `uart_tx` start bit begins the cycle after the transmitter loads.
- `mem_rdata` returns to 0 whenever `mem_ready`=0.

## Configuration
- `SS_UART_RX_EN` defined: the receiver, synchroniser, rx_valid and rx_overrun are built.
- `SS_UART_RX_EN` undefined:
  - `uart_rx` is unused.
  - DATA reads return 0.
  - STATUS bits 2:1 read 0.
  - The TX path and bus behaviour are unchanged.

## Test plan
- SRAM byte lanes: write 0x1122_3344 to 0x40 with wstrb=0xF, then write 0x0000_AA00 with wstrb=0x2, then read 0x40 -> 0x1122_AA44, with `mem_ready` one cycle high at the required latency.
- TX frame (CLK_DIV=16): write 0xA5 to DATA -> `uart_tx` shows 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles. STATUS bit0=1 during the frame and 0 afterwards.
- TX back-pressure: two DATA writes back to back -> the second `mem_ready` is withheld until the first stop bit ends, and the second frame follows with no gap.
- RX with `SS_UART_RX_EN`:
  - Drive 0x3C on `uart_rx` -> STATUS=0x2, then DATA read=0x3C, then STATUS=0x0.
  - Send two bytes without reading -> STATUS=0x6; a DATA read returns the first byte.
- Reset mid-frame: assert `reset` during TX bit 4 -> `uart_tx`=1 and `mem_ready`=0 immediately, STATUS reads 0 after release.
- Unmapped access: read 0x2000_0000 -> rdata=0 and `mem_ready` pulses; a write there changes no SRAM or UART state.

Source files
------------

// File: rtl/ss_bus_responder.sv
// ss_bus_responder: mem_* bus target serving a word SRAM and a two-register UART.
// Optional receiver built when SS_UART_RX_EN is defined; TX-only otherwise.
module ss_bus_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int CLK_DIV   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DIV_MID  = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, WAIT_TX, RESP, TURN} state_t;

    state_t        state, state_nx;
    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   rd_val, resp_q;
    logic          sram_sel, data_sel, stat_sel, is_wr;
    logic [AW-1:0] widx;
    logic          accept, tx_load, data_rd, stat_rd;

    logic          tx_busy, tx_last, tx_free;
    logic [9:0]    tx_sh;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;

    logic          rx_valid, rx_overrun;
    logic [7:0]    rx_byte;
    logic          unused_addr;

    assign sram_sel    = (mem_addr[31:AW+2] == '0);
    assign data_sel    = (mem_addr[31:2] == 30'h0400_0000);
    assign stat_sel    = (mem_addr[31:2] == 30'h0400_0001);
    assign is_wr       = |mem_wstrb;
    assign widx        = mem_addr[AW+1:2];
    assign data_rd     = accept && data_sel && !is_wr;
    assign stat_rd     = accept && stat_sel && !is_wr;
    assign unused_addr = ^mem_addr[1:0];

    assign tx_last = tx_busy && (tx_bit == 4'd9) && (tx_cnt == DIV_LAST);
    assign tx_free = !tx_busy || tx_last;
    assign uart_tx = tx_sh[0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state; a stalled DATA write loads on the stop bit's last cycle so frames abut
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        tx_load  = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (data_sel && is_wr && tx_busy) begin
                        state_nx = WAIT_TX;
                    end else begin
                        state_nx = RESP;
                        accept   = 1'b1;
                        tx_load  = data_sel && mem_wstrb[0];
                    end
                end
            end
            WAIT_TX: begin
                if (tx_free) begin
                    state_nx = RESP;
                    tx_load  = mem_wstrb[0];
                end
            end
            RESP:    state_nx = TURN;
            TURN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read mux for the addressed target
    always_comb begin
        rd_val = '0;
        if (sram_sel)      rd_val = mem[widx];
        else if (stat_sel) rd_val = {29'b0, rx_overrun, rx_valid, tx_busy};
        else if (data_sel) rd_val = {24'b0, rx_byte};
    end

    // SRAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (accept && sram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wstrb[i]) mem[widx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Response capture and one-cycle ready pulse; rdata is zero outside the pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_q    <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            if (state == IDLE && mem_valid) resp_q <= is_wr ? '0 : rd_val;
            mem_ready <= (state == RESP);
            mem_rdata <= (state == RESP) ? resp_q : '0;
        end
    end

    // Transmitter: 10-bit frame shifted out LSB first, line idles at all ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_bit  <= '0;
            tx_cnt  <= '0;
        end else if (tx_load) begin
            tx_busy <= 1'b1;
            tx_sh   <= {1'b1, mem_wdata[7:0], 1'b0};
            tx_bit  <= '0;
            tx_cnt  <= '0;
        end else if (tx_busy) begin
            if (tx_cnt == DIV_LAST) begin
                tx_cnt <= '0;
                tx_sh  <= {1'b1, tx_sh[9:1]};
                if (tx_bit == 4'd9) tx_busy <= 1'b0;
                else                tx_bit  <= tx_bit + 4'd1;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

`ifdef SS_UART_RX_EN
    logic          rx_s1, rx_s2, rx_s3, rx_busy, rx_mid, rx_done;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;

    assign rx_mid  = rx_busy && (rx_cnt == DIV_MID);
    assign rx_done = rx_mid && (rx_bit == 4'd9) && rx_s2;

    // Synchroniser and mid-bit sampling receiver
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_s3   <= 1'b1;
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (!rx_busy) begin
                if (!rx_s2 && rx_s3) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
            end else begin
                rx_cnt <= (rx_cnt == DIV_LAST) ? '0 : rx_cnt + 1'b1;
                if (rx_cnt == DIV_LAST) rx_bit <= rx_bit + 4'd1;
                if (rx_mid) begin
                    if (rx_bit == 4'd0) begin
                        if (rx_s2) rx_busy <= 1'b0;
                    end else if (rx_bit == 4'd9) begin
                        rx_busy <= 1'b0;
                    end else begin
                        rx_sh <= {rx_s2, rx_sh[7:1]};
                    end
                end
            end
        end
    end

    // Holding register; a byte landing with a DATA read replaces the one being read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (stat_rd) rx_overrun <= 1'b0;
            if (rx_done) begin
                if (!rx_valid || data_rd) begin
                    rx_byte  <= rx_sh;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (data_rd) begin
                rx_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_rx;
    assign rx_byte    = '0;
    assign rx_valid   = 1'b0;
    assign rx_overrun = 1'b0;
    assign unused_rx  = ^{uart_rx, data_rd, stat_rd};
`endif

endmodule

// File: tb/tb_ss_bus_responder.sv
// Scoreboard bench for ss_bus_responder: bus requests push expected rdata,
// a negedge monitor pops on every mem_ready; UART lines checked bit by bit.
module tb_ss_bus_responder;

    localparam int DIV = 16;
    localparam logic [31:0] A_DATA = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0004;

    typedef struct packed {
        logic        chk;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   f1_done = 0;

    ss_bus_responder #(.MEM_WORDS(1024), .CLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every ready pulse consumes one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (mem_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got ready=1 expected none, rdata %h", mem_rdata);
            end else begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    n_cmp++;
                    if (mem_rdata !== e.exp) begin
                        n_bad++;
                        $display("FAIL rdata: got %h expected %h", mem_rdata, e.exp);
                    end
                end
            end
        end else begin
            n_cmp++;
            if (mem_rdata !== 32'h0) begin
                n_bad++;
                $display("FAIL rdata_idle: got %h expected 00000000", mem_rdata);
            end
        end
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit chk, input logic [31:0] exp, output int k);
        exp_t e;
        e.chk = chk;
        e.exp = exp;
        sb_q.push_back(e);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mem_ready && k < 400);
        if (!mem_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got no ready expected ready, addr %h", a);
            void'(sb_q.pop_back());
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        int k;
        bus(a, 32'h0, 4'h0, 1'b1, exp, k);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        bus(a, d, s, 1'b0, 32'h0, k);
    endtask

    // Frame checker: each of the 10 bits must hold for DIV consecutive cycles
    task automatic check_frame(input logic [7:0] b, input bit wait_start);
        logic [9:0] fr;
        int t;
        bit bad;
        fr = {1'b1, b, 1'b0};
        t = 0;
        if (wait_start) begin
            @(negedge clk);
            while (uart_tx !== 1'b0 && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (uart_tx !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_start_timeout: got %b expected 0", uart_tx);
                return;
            end
        end else begin
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            bad = 0;
            for (int c = 0; c < DIV; c++) begin
                if (!(i == 0 && c == 0)) @(negedge clk);
                if (uart_tx !== fr[i]) bad = 1;
            end
            n_cmp++;
            if (bad) begin
                n_bad++;
                $display("FAIL tx_bit%0d byte %h: got unstable/wrong expected %b", i, b, fr[i]);
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (DIV) @(negedge clk);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("reset_ready", {31'b0, mem_ready}, 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // SRAM byte lanes and latency
        wr(32'h40, 32'h1122_3344, 4'hF);
        wr(32'h40, 32'h0000_AA00, 4'h2);
        bus(32'h40, 32'h0, 4'h0, 1'b1, 32'h1122_AA44, k);
        check("read_latency", k, 32'd2);

        // Top word and the first unmapped word above SRAM
        wr(32'hFFC, 32'hCAFE_F00D, 4'hF);
        wr(32'h0, 32'h0000_0055, 4'hF);
        wr(32'h1000, 32'h0000_0077, 4'hF);
        rd(32'h0, 32'h0000_0055);
        rd(32'hFFC, 32'hCAFE_F00D);
        rd(32'h1000, 32'h0);

        // Unmapped region
        rd(32'h2000_0000, 32'h0);
        wr(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        rd(32'h40, 32'h1122_AA44);
        rd(A_STAT, 32'h0);

        // Single TX frame, busy during and idle after
        fork
            check_frame(8'hA5, 1'b1);
            begin
                wr(A_DATA, 32'h0000_00A5, 4'h1);
                rd(A_STAT, 32'h1);
            end
        join
        repeat (3) @(negedge clk);
        rd(A_STAT, 32'h0);

        // DATA write with lane 0 clear: acknowledged, nothing sent
        wr(A_DATA, 32'h0000_FF00, 4'h2);
        rd(A_STAT, 32'h0);
        wr(A_STAT, 32'h0000_0007, 4'hF);
        rd(A_STAT, 32'h0);

        // Back-pressure: second write waits, frames abut
        fork
            begin
                check_frame(8'h5A, 1'b1);
                f1_done = 1;
                check_frame(8'hC3, 1'b0);
            end
            begin
                wr(A_DATA, 32'h0000_005A, 4'h1);
                wr(A_DATA, 32'h0000_00C3, 4'h1);
                check("stall_until_stop", {31'b0, f1_done}, 32'h1);
            end
        join
        repeat (3) @(negedge clk);
        rd(A_STAT, 32'h0);

`ifdef SS_UART_RX_EN
        send_rx(8'h3C, 1'b1);
        rd(A_STAT, 32'h2);
        rd(A_DATA, 32'h3C);
        rd(A_STAT, 32'h0);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd(A_STAT, 32'h6);
        rd(A_DATA, 32'h11);
        rd(A_STAT, 32'h0);
        send_rx(8'h55, 1'b0);
        rd(A_STAT, 32'h0);
`else
        send_rx(8'h3C, 1'b1);
        rd(A_STAT, 32'h0);
        rd(A_DATA, 32'h0);
`endif

        // Reset during TX bit 4 with a STATUS read in flight
        wr(A_DATA, 32'h0000_0000, 4'h1);
        repeat (66) @(negedge clk);
        check("tx_bit4_low", {31'b0, uart_tx}, 32'h0);
        mem_addr  = A_STAT;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        mem_valid = 1'b0;
        #1;
        check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("rst_ready", {31'b0, mem_ready}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_uart_tx", {31'b0, uart_tx}, 32'h1);
        rd(A_STAT, 32'h0);
        rd(32'h40, 32'h1122_AA44);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
